bus_sched: RTL and testbench

- Sequential bus-ownership scheduler for the KS10 backplane.
- Decides which requester owns the shared memory/Unibus datapath: console (CSL), Unibus adapters UBA1–UBA4, or CPU.
- Holds ownership for the whole transaction until acknowledge, abort or timeout, then forces a turnaround cycle.
- Outputs are registered one-hot grants. The downstream combinational bus multiplexer steers address, data and ACK from these grants instead of deriving ownership from raw requests.

---
 rtl/ks10_arb_pkg.sv | 36 +++
 rtl/arb_rr4.sv | 21 ++
 rtl/bus_sched.sv | 107 ++++++++++
 tb/tb_bus_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ks10_arb_pkg.sv
// Shared types and constants for the KS10 backplane bus-ownership scheduler.
package ks10_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  localparam logic [2:0] OWN_NONE = 3'd0;
  localparam logic [2:0] OWN_CSL  = 3'd1;
  localparam logic [2:0] OWN_UBA1 = 3'd2;
  localparam logic [2:0] OWN_UBA2 = 3'd3;
  localparam logic [2:0] OWN_UBA3 = 3'd4;
  localparam logic [2:0] OWN_UBA4 = 3'd5;
  localparam logic [2:0] OWN_CPU  = 3'd6;

  localparam int TIMEOUT_DEF = 64;
  localparam int STARVE_DEF  = 16;
  localparam int CNTW_DEF    = 8;

  // Grant vector layout: {cpu, uba4, uba3, uba2, uba1, csl}
  function automatic logic [2:0] owner_code(input logic [5:0] gnt);
    if (gnt[0])      return OWN_CSL;
    else if (gnt[1]) return OWN_UBA1;
    else if (gnt[2]) return OWN_UBA2;
    else if (gnt[3]) return OWN_UBA3;
    else if (gnt[4]) return OWN_UBA4;
    else if (gnt[5]) return OWN_CPU;
    else             return OWN_NONE;
  endfunction

  function automatic logic [1:0] rr_index(input logic [3:0] onehot);
    if (onehot[1])      return 2'd1;
    else if (onehot[2]) return 2'd2;
    else if (onehot[3]) return 2'd3;
    else                return 2'd0;
  endfunction

endpackage

// File: rtl/arb_rr4.sv
// Combinational 4-way round-robin picker; search begins just after the last winner.
module arb_rr4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] pick,
  output logic       valid
);

  always_comb begin
    logic [1:0] idx;
    pick = '0;
    idx  = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (pick == 4'b0 && req[idx]) pick[idx] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/bus_sched.sv
// KS10 bus-ownership scheduler: registered one-hot grants held per transaction.
// state | meaning:  IDLE pick winner | OWN grant held until ack/abort/timeout | TURN one dead cycle
module bus_sched
  import ks10_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int STARVE  = STARVE_DEF,
  parameter int CNTW    = CNTW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cslREQI,
  input  logic [3:0] ubaREQI,
  input  logic       cpuREQI,
  input  logic       ackI,
  output logic       gntCSL,
  output logic [3:0] gntUBA,
  output logic       gntCPU,
  output logic       busBUSY,
  output logic       tmoO,
  output logic [2:0] owner
);

  localparam logic [CNTW-1:0] TMO_LAST   = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] STARVE_THR = CNTW'(STARVE);
  localparam logic [CNTW-1:0] CNT_MAX    = '1;

  state_t          state, state_nxt;
  logic [5:0]      gnt, gnt_nxt, req, winner;
  logic [CNTW-1:0] tmo_cnt, starve_cnt;
  logic [1:0]      rr_last;
  logic [3:0]      rr_pick;
  logic            rr_valid;
  logic            starve_flag, owner_req, tmo_last, own_done;

  assign req         = {cpuREQI, ubaREQI, cslREQI};
  assign starve_flag = starve_cnt >= STARVE_THR;
  assign owner_req   = |(gnt & req);
  assign tmo_last    = tmo_cnt == TMO_LAST;
  assign own_done    = ackI || !owner_req || tmo_last;

  arb_rr4 u_rr (
    .req   (ubaREQI),
    .last  (rr_last),
    .pick  (rr_pick),
    .valid (rr_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = OWN;
      OWN:     if (own_done) state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    winner = '0;
    if (starve_flag && cpuREQI) winner = 6'b100000;
    else if (cslREQI)           winner = 6'b000001;
    else if (rr_valid)          winner = {1'b0, rr_pick, 1'b0};
    else if (cpuREQI)           winner = 6'b100000;

    gnt_nxt = gnt;
    case (state)
      IDLE:    gnt_nxt = winner;
      OWN:     if (own_done) gnt_nxt = '0;
      TURN:    gnt_nxt = '0;
      default: gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
      rr_last    <= 2'd3;
    end else begin
      gnt <= gnt_nxt;

      if (state == OWN && !own_done) tmo_cnt <= tmo_cnt + CNTW'(1);
      else                           tmo_cnt <= '0;

      if (state == IDLE && |gnt_nxt[4:1]) rr_last <= rr_index(gnt_nxt[4:1]);

      if (!cpuREQI || gnt[5])          starve_cnt <= '0;
      else if (starve_cnt != CNT_MAX)  starve_cnt <= starve_cnt + CNTW'(1);
    end
  end

  // Qualified by ackI so an acknowledge in the final grant cycle wins over the timeout.
  assign tmoO    = (state == OWN) && tmo_last && owner_req && !ackI;
  assign gntCSL  = gnt[0];
  assign gntUBA  = gnt[4:1];
  assign gntCPU  = gnt[5];
  assign busBUSY = |gnt;
  assign owner   = owner_code(gnt);

endmodule

// File: tb/tb_bus_sched.sv
// Directed bench for bus_sched: hand-computed grant/owner/tmo expectations per cycle.
module tb_bus_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cslREQI = 1'b0;
  logic [3:0] ubaREQI = 4'b0;
  logic       cpuREQI = 1'b0;
  logic       ackI = 1'b0;
  logic       gntCSL, gntCPU, busBUSY, tmoO;
  logic [3:0] gntUBA;
  logic [2:0] owner;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] G_NONE = 6'b000000;
  localparam logic [5:0] G_CSL  = 6'b000001;
  localparam logic [5:0] G_UBA1 = 6'b000010;
  localparam logic [5:0] G_UBA2 = 6'b000100;
  localparam logic [5:0] G_UBA3 = 6'b001000;
  localparam logic [5:0] G_CPU  = 6'b100000;

  bus_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cslREQI (cslREQI),
    .ubaREQI (ubaREQI),
    .cpuREQI (cpuREQI),
    .ackI    (ackI),
    .gntCSL  (gntCSL),
    .gntUBA  (gntUBA),
    .gntCPU  (gntCPU),
    .busBUSY (busBUSY),
    .tmoO    (tmoO),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] eg, input logic [2:0] eo, input logic et);
    logic [5:0] g;
    logic       eb;
    g  = {gntCPU, gntUBA, gntCSL};
    eb = (eg != 6'b0);
    checks++;
    assert (g === eg) else begin
      failures++;
      $error("FAIL %s grants got=%b exp=%b", tag, g, eg);
    end
    checks++;
    assert (owner === eo) else begin
      failures++;
      $error("FAIL %s owner got=%0d exp=%0d", tag, owner, eo);
    end
    checks++;
    assert (busBUSY === eb) else begin
      failures++;
      $error("FAIL %s busBUSY got=%b exp=%b", tag, busBUSY, eb);
    end
    checks++;
    assert (tmoO === et) else begin
      failures++;
      $error("FAIL %s tmoO got=%b exp=%b", tag, tmoO, et);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    assert ($onehot0({gntCPU, gntUBA, gntCSL})) else begin
      failures++;
      $error("FAIL onehot grants got=%b exp=at_most_one", {gntCPU, gntUBA, gntCSL});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // reset state
    step();
    step();
    chk("reset", G_NONE, 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", G_NONE, 3'd0, 1'b0);

    // CPU alone, ack in third grant cycle
    cpuREQI = 1'b1;
    step(); chk("cpu_g1", G_CPU, 3'd6, 1'b0);
    step(); chk("cpu_g2", G_CPU, 3'd6, 1'b0);
    step(); chk("cpu_g3", G_CPU, 3'd6, 1'b0);
    ackI = 1'b1;
    step(); chk("cpu_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0; cpuREQI = 1'b0;
    step(); chk("cpu_idle", G_NONE, 3'd0, 1'b0);

    // CSL beats CPU when starvation flag is clear
    cslREQI = 1'b1; cpuREQI = 1'b1;
    step(); chk("csl_first", G_CSL, 3'd1, 1'b0);
    ackI = 1'b1;
    step(); chk("csl_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0; cslREQI = 1'b0;
    step(); chk("csl_idle", G_NONE, 3'd0, 1'b0);
    step(); chk("cpu_after_csl", G_CPU, 3'd6, 1'b0);
    ackI = 1'b1; cpuREQI = 1'b0;
    step(); chk("cpu2_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0;
    step(); chk("cpu2_idle", G_NONE, 3'd0, 1'b0);

    // UBA round robin: 1,2,3,4,1
    ubaREQI = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(); chk("rr_g1", G_UBA1 << (k % 4), 3'(2 + (k % 4)), 1'b0);
      step(); chk("rr_g2", G_UBA1 << (k % 4), 3'(2 + (k % 4)), 1'b0);
      ackI = 1'b1;
      step(); chk("rr_turn", G_NONE, 3'd0, 1'b0);
      ackI = 1'b0;
      step(); chk("rr_idle", G_NONE, 3'd0, 1'b0);
    end
    ubaREQI = 4'b0000;
    step(); chk("rr_quiet", G_NONE, 3'd0, 1'b0);

    // starvation: CSL keeps winning until CPU counter passes STARVE
    cpuREQI = 1'b1; cslREQI = 1'b1; ubaREQI = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      step(); chk("starve_csl", G_CSL, 3'd1, 1'b0);
      ackI = 1'b1;
      step(); chk("starve_turn", G_NONE, 3'd0, 1'b0);
      ackI = 1'b0;
      step(); chk("starve_idle", G_NONE, 3'd0, 1'b0);
    end
    step(); chk("starve_cpu", G_CPU, 3'd6, 1'b0);
    ackI = 1'b1;
    step(); chk("starve_cpu_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0;
    step(); chk("starve_cpu_idle", G_NONE, 3'd0, 1'b0);
    step(); chk("starve_cleared", G_CSL, 3'd1, 1'b0);
    ackI = 1'b1; cslREQI = 1'b0; cpuREQI = 1'b0;
    step(); chk("starve_csl_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0;
    step(); chk("starve_csl_idle", G_NONE, 3'd0, 1'b0);
    step(); chk("rr_uba3", G_UBA3, 3'd4, 1'b0);
    ackI = 1'b1; ubaREQI = 4'b0000;
    step(); chk("uba3_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0;
    step(); chk("uba3_idle", G_NONE, 3'd0, 1'b0);

    // timeout on UBA2: pulse at grant cycle 64
    ubaREQI = 4'b0010;
    step(); chk("tmo_g1", G_UBA2, 3'd3, 1'b0);
    for (int c = 2; c <= 63; c++) begin
      step(); chk("tmo_wait", G_UBA2, 3'd3, 1'b0);
    end
    step(); chk("tmo_pulse", G_UBA2, 3'd3, 1'b1);
    ubaREQI = 4'b0000;
    step(); chk("tmo_turn", G_NONE, 3'd0, 1'b0);
    step(); chk("tmo_idle", G_NONE, 3'd0, 1'b0);

    // ack on grant cycle 64 beats the timeout
    ubaREQI = 4'b0010;
    step(); chk("ack64_g1", G_UBA2, 3'd3, 1'b0);
    for (int c = 2; c <= 63; c++) begin
      step(); chk("ack64_wait", G_UBA2, 3'd3, 1'b0);
    end
    step();
    ackI = 1'b1;
    #1;
    chk("ack64_no_tmo", G_UBA2, 3'd3, 1'b0);
    ubaREQI = 4'b0000;
    step(); chk("ack64_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0;
    step(); chk("ack64_idle", G_NONE, 3'd0, 1'b0);

    // asynchronous reset mid-OWN
    cslREQI = 1'b1;
    step(); chk("rst_g1", G_CSL, 3'd1, 1'b0);
    step(); chk("rst_g2", G_CSL, 3'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", G_NONE, 3'd0, 1'b0);
    #1 rst_n = 1'b1;
    step(); chk("rst_regrant", G_CSL, 3'd1, 1'b0);
    ackI = 1'b1; cslREQI = 1'b0;
    step(); chk("rst_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0;
    step(); chk("rst_idle", G_NONE, 3'd0, 1'b0);
    ubaREQI = 4'b1111;
    step(); chk("rst_rr_uba1", G_UBA1, 3'd2, 1'b0);
    ackI = 1'b1; ubaREQI = 4'b0000;
    step(); chk("rst_rr_turn", G_NONE, 3'd0, 1'b0);
    ackI = 1'b0;
    step(); chk("rst_rr_idle", G_NONE, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
